// File: rtl/spike_out_collector.sv
// Spike output collector: timestamps per-column spike pulses and round-robin serialises them into a FWFT event FIFO.
// Optional macro SPIKE_OUT_DROP_CNT_EN adds a saturating drop_count output.
module spike_out_collector #(
    parameter int NUM_COLS   = 2,
    parameter int TIME_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int AW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int LW = PW + 1,
    localparam int EW = AW + TIME_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  time_en,
    input  logic [NUM_COLS-1:0]   neuron_spike,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AW-1:0]         out_addr,
    output logic [TIME_WIDTH-1:0] out_time,
    output logic [LW-1:0]         fifo_level,
    output logic                  overflow,
    input  logic                  overflow_clr
`ifdef SPIKE_OUT_DROP_CNT_EN
    ,
    output logic [7:0]            drop_count
`endif
);

    function automatic logic [AW-1:0] rr_index(input logic [AW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        return (sum >= NUM_COLS) ? AW'(sum - NUM_COLS) : AW'(sum);
    endfunction

    function automatic logic [7:0] count_ones(input logic [NUM_COLS-1:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < NUM_COLS; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    logic [TIME_WIDTH-1:0] r_time;
    logic [NUM_COLS-1:0]   r_pending;
    logic [TIME_WIDTH-1:0] r_stamp [NUM_COLS];
    logic [AW-1:0]         r_rr_ptr;
    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_out_valid;
    logic [AW-1:0]         r_out_addr;
    logic [TIME_WIDTH-1:0] r_out_time;
    logic                  r_overflow;

    logic                  w_pop;
    logic                  w_can_push;
    logic                  w_grant;
    logic [AW-1:0]         w_gidx;
    logic [NUM_COLS-1:0]   w_drop;
    logic [7:0]            w_ndrops;
    logic [EW-1:0]         w_push_data;
    logic [LW-1:0]         w_level_after_pop;
    logic [LW-1:0]         w_level_next;
    logic [PW-1:0]         w_rd_next;
    logic [EW-1:0]         w_head_next;

    // Round-robin grant: first pending column at or after the pointer, only when the FIFO can take a push.
    always_comb begin
        w_pop      = r_out_valid & out_ready;
        w_can_push = (r_level < LW'(FIFO_DEPTH)) | w_pop;
        w_grant    = 1'b0;
        w_gidx     = {AW{1'b0}};
        for (int k = 0; k < NUM_COLS; k++) begin
            w_gidx  = (!w_grant && w_can_push && r_pending[rr_index(r_rr_ptr, k)]) ?
                      rr_index(r_rr_ptr, k) : w_gidx;
            w_grant = w_grant | (w_can_push & r_pending[rr_index(r_rr_ptr, k)]);
        end
    end

    // A spike is lost when its column is still pending and is not being granted this cycle.
    always_comb begin
        w_drop = {NUM_COLS{1'b0}};
        for (int i = 0; i < NUM_COLS; i++) begin
            w_drop[i] = neuron_spike[i] & r_pending[i] & ~(w_grant & (w_gidx == AW'(i)));
        end
        w_ndrops = count_ones(w_drop);
    end

    // Next FIFO occupancy and next head entry for the registered FWFT outputs.
    always_comb begin
        w_push_data       = {w_gidx, r_stamp[w_gidx]};
        w_level_after_pop = r_level - LW'(w_pop);
        w_level_next      = w_level_after_pop + LW'(w_grant);
        w_rd_next         = r_rd_ptr + PW'(w_pop);
        if (w_level_after_pop == {LW{1'b0}}) begin
            w_head_next = w_grant ? w_push_data : {r_out_addr, r_out_time};
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // Free-running timestamp counter, wraps silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_time <= {TIME_WIDTH{1'b0}};
        end else if (time_en) begin
            r_time <= r_time + TIME_WIDTH'(1);
        end else begin
            r_time <= r_time;
        end
    end

    // Per-column capture; a fresh spike on a column being granted re-arms it with the new stamp.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= {NUM_COLS{1'b0}};
            r_rr_ptr  <= {AW{1'b0}};
            for (int i = 0; i < NUM_COLS; i++) begin
                r_stamp[i] <= {TIME_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_COLS; i++) begin
                if (neuron_spike[i] && !w_drop[i]) begin
                    r_pending[i] <= 1'b1;
                    r_stamp[i]   <= r_time;
                end else if (w_grant && (w_gidx == AW'(i))) begin
                    r_pending[i] <= 1'b0;
                end else begin
                    r_pending[i] <= r_pending[i];
                end
            end
            if (w_grant) begin
                r_rr_ptr <= rr_index(w_gidx, 1);
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
        end
    end

    // Event FIFO storage, pointers and registered head outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= {PW{1'b0}};
            r_rd_ptr    <= {PW{1'b0}};
            r_level     <= {LW{1'b0}};
            r_out_valid <= 1'b0;
            r_out_addr  <= {AW{1'b0}};
            r_out_time  <= {TIME_WIDTH{1'b0}};
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                r_mem[j] <= {EW{1'b0}};
            end
        end else begin
            if (w_grant) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            r_rd_ptr                 <= w_rd_next;
            r_level                  <= w_level_next;
            r_out_valid              <= (w_level_next != {LW{1'b0}});
            {r_out_addr, r_out_time} <= w_head_next;
        end
    end

    // Sticky loss flag; a drop in the clearing cycle wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (|w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

`ifdef SPIKE_OUT_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic [8:0] w_cnt_sum;

    assign w_cnt_sum = {1'b0, r_drop_cnt} + {1'b0, w_ndrops};

    // Saturating drop counter; clearing loads this cycle's drops so none are forgotten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= 8'd0;
        end else if (overflow_clr) begin
            r_drop_cnt <= w_ndrops;
        end else begin
            r_drop_cnt <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
        end
    end

    assign drop_count = r_drop_cnt;
`endif

    assign out_valid  = r_out_valid;
    assign out_addr   = r_out_addr;
    assign out_time   = r_out_time;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_spike_out_collector.sv
// Testbench for spike_out_collector: directed scenarios plus random traffic against a queue-based event model.
module tb_spike_out_collector;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       time_en = 1'b1;
    logic [1:0] spk = 2'b00;
    logic       out_ready = 1'b0;
    logic       overflow_clr = 1'b0;
    logic       out_valid, overflow, out_addr;
    logic [15:0] out_time;
    logic [3:0] fifo_level;
    logic       w_out_valid, w_overflow, w_out_addr;
    logic [3:0] w_out_time;
    logic [3:0] w_fifo_level;
`ifdef SPIKE_OUT_DROP_CNT_EN
    logic [7:0] drop_count, w_drop_count;
`endif

    int errors = 0;
    int n_checks = 0;

    // Event model: queue of (column, stamp) in push order
    int m_time;
    bit m_pend [2];
    int m_stamp [2];
    int m_ptr;
    int m_q [$];
    bit m_ovf;
    int m_dcnt;
    int m_oaddr, m_otime;

    always #5 clk = ~clk;

    spike_out_collector dut (
        .clk(clk), .reset_n(reset_n), .time_en(time_en), .neuron_spike(spk),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_time(out_time), .fifo_level(fifo_level), .overflow(overflow),
        .overflow_clr(overflow_clr)
`ifdef SPIKE_OUT_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    spike_out_collector #(.TIME_WIDTH(4)) dut_w (
        .clk(clk), .reset_n(reset_n), .time_en(time_en), .neuron_spike(spk),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_addr(w_out_addr),
        .out_time(w_out_time), .fifo_level(w_fifo_level), .overflow(w_overflow),
        .overflow_clr(overflow_clr)
`ifdef SPIKE_OUT_DROP_CNT_EN
        , .drop_count(w_drop_count)
`endif
    );

    task automatic model_reset();
        m_time = 0; m_ptr = 0; m_ovf = 1'b0; m_dcnt = 0;
        m_oaddr = 0; m_otime = 0;
        m_q.delete();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0;
            m_stamp[i] = 0;
        end
    endtask

    // Apply one clock edge to both the model and the DUTs.
    task automatic tick();
        bit pop, can;
        int g, drops;
        pop = (m_q.size() > 0) && out_ready;
        can = (m_q.size() < 8) || pop;
        g = -1;
        if (can) begin
            for (int k = 0; k < 2; k++) begin
                int c;
                c = (m_ptr + k) % 2;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        drops = 0;
        for (int i = 0; i < 2; i++)
            if (spk[i] && m_pend[i] && g != i) drops++;
        if (pop) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(g * 65536 + m_stamp[g]);
            m_pend[g] = 1'b0;
            m_ptr = (g + 1) % 2;
        end
        for (int i = 0; i < 2; i++) begin
            if (spk[i] && !m_pend[i]) begin
                m_pend[i] = 1'b1;
                m_stamp[i] = m_time;
            end
        end
        if (time_en) m_time = (m_time + 1) % 65536;
        if (drops > 0) m_ovf = 1'b1;
        else if (overflow_clr) m_ovf = 1'b0;
        if (overflow_clr) m_dcnt = drops;
        else m_dcnt = (m_dcnt + drops > 255) ? 255 : m_dcnt + drops;
        if (m_q.size() > 0) begin
            m_oaddr = m_q[0] / 65536;
            m_otime = m_q[0] % 65536;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        spk = 2'b00; out_ready = 1'b0; overflow_clr = 1'b0; time_en = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_time(input int t, input int modulus);
        for (int n = 0; n < 200 && (m_time % modulus) != t; n++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        n_checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
        n_checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b want=0", overflow); end
        n_checks++; if (out_addr !== 1'b0 || out_time !== 16'd0) begin errors++; $display("FAIL reset_head got=%0d/%0d want=0/0", out_addr, out_time); end
`ifdef SPIKE_OUT_DROP_CNT_EN
        n_checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_dcnt got=%0d want=0", drop_count); end
`endif
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        wait_time(5, 65536);
        spk = 2'b10;
        tick();
        spk = 2'b00;
        n_checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%0b want=0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_addr !== 1'b1 || out_time !== 16'd5) begin
            errors++; $display("FAIL single_event got=v%0b a%0d t%0d want=v1 a1 t5", out_valid, out_addr, out_time); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++; $display("FAIL single_after got=v%0b l%0d want=v0 l0", out_valid, fifo_level); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        out_ready = 1'b1;
        for (int r = 1; r <= 2; r++) begin
            wait_time(10 * r, 65536);
            spk = 2'b11;
            tick();
            spk = 2'b00;
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_addr !== 1'b0 || out_time !== 16'(10 * r)) begin
                errors++; $display("FAIL simul_first got=v%0b a%0d t%0d want=v1 a0 t%0d", out_valid, out_addr, out_time, 10 * r); end
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_addr !== 1'b1 || out_time !== 16'(10 * r)) begin
                errors++; $display("FAIL simul_second got=v%0b a%0d t%0d want=v1 a1 t%0d", out_valid, out_addr, out_time, 10 * r); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int cnt;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            spk = (k % 2 == 1) ? 2'b10 : 2'b01;
            tick();
            spk = 2'b00;
            tick();
        end
        n_checks++; if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
            errors++; $display("FAIL bp_full got=l%0d o%0b want=l8 o0", fifo_level, overflow); end
        spk = 2'b01;
        tick();
        spk = 2'b00;
        tick();
        n_checks++; if (overflow !== 1'b1 || fifo_level !== 4'd8) begin
            errors++; $display("FAIL bp_ovf got=o%0b l%0d want=o1 l8", overflow, fifo_level); end
        out_ready = 1'b1;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (out_valid) cnt++;
            n_checks++; if (out_valid !== (m_q.size() > 0) || (out_valid && (out_addr !== 1'(m_oaddr) || out_time !== 16'(m_otime)))) begin
                errors++; $display("FAIL bp_drain got=v%0b a%0d t%0d want=v%0b a%0d t%0d", out_valid, out_addr, out_time, m_q.size() > 0, m_oaddr, m_otime); end
            tick();
        end
        n_checks++; if (cnt !== 10) begin errors++; $display("FAIL bp_count got=%0d want=10", cnt); end
    endtask

    task automatic test_collision();
        int a;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            spk = 2'b10;
            tick();
            spk = 2'b00;
            tick();
        end
        a = m_time;
        spk = 2'b01;
        tick();
        tick();
        spk = 2'b00;
        n_checks++; if (overflow !== 1'b1 || fifo_level !== 4'd8) begin
            errors++; $display("FAIL coll_ovf got=o%0b l%0d want=o1 l8", overflow, fifo_level); end
`ifdef SPIKE_OUT_DROP_CNT_EN
        n_checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL coll_dcnt got=%0d want=1", drop_count); end
`endif
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL coll_clr got=%0b want=0", overflow); end
`ifdef SPIKE_OUT_DROP_CNT_EN
        n_checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL coll_dcnt_clr got=%0d want=0", drop_count); end
`endif
        spk = 2'b01;
        overflow_clr = 1'b1;
        tick();
        spk = 2'b00;
        overflow_clr = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL coll_clr_prio got=%0b want=1", overflow); end
`ifdef SPIKE_OUT_DROP_CNT_EN
        n_checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL coll_dcnt_prio got=%0d want=1", drop_count); end
`endif
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (out_valid && out_addr == 1'b0) begin
                n_checks++; if (out_time !== 16'(a)) begin errors++; $display("FAIL coll_stamp got=%0d want=%0d", out_time, a); end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        wait_time(15, 16);
        spk = 2'b01;
        tick();
        spk = 2'b00;
        tick();
        n_checks++; if (w_out_valid !== 1'b1 || w_out_time !== 4'd15) begin
            errors++; $display("FAIL wrap_first got=v%0b t%0d want=v1 t15", w_out_valid, w_out_time); end
        spk = 2'b01;
        tick();
        spk = 2'b00;
        tick();
        n_checks++; if (w_out_valid !== 1'b1 || w_out_time !== 4'd1) begin
            errors++; $display("FAIL wrap_second got=v%0b t%0d want=v1 t1", w_out_valid, w_out_time); end
        n_checks++; if (out_time !== 16'(m_otime)) begin errors++; $display("FAIL wrap_wide got=%0d want=%0d", out_time, m_otime); end
    endtask

    task automatic test_async_reset();
        do_reset();
        spk = 2'b11; tick();
        spk = 2'b10; tick();
        spk = 2'b00; tick(); tick();
        spk = 2'b01; tick();
        spk = 2'b00; tick();
        spk = 2'b11; tick();
        spk = 2'b00;
        n_checks++; if (fifo_level !== 4'd3 || overflow !== 1'b1) begin
            errors++; $display("FAIL arst_pre got=l%0d o%0b want=l3 o1", fifo_level, overflow); end
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (out_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL arst_now got=v%0b l%0d o%0b want=v0 l0 o0", out_valid, fifo_level, overflow); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0 || w_out_valid !== 1'b0) begin
                errors++; $display("FAIL arst_stale got=%0b/%0b want=0", out_valid, w_out_valid); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 500; n++) begin
            spk          = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            out_ready    = ($urandom_range(0, 2) != 0);
            time_en      = ($urandom_range(0, 4) != 0);
            overflow_clr = ($urandom_range(0, 15) == 0);
            tick();
            n_checks++; if (out_valid !== (m_q.size() > 0) || fifo_level !== 4'(m_q.size())) begin
                errors++; $display("FAIL rnd_occ cyc=%0d got=v%0b l%0d want=v%0b l%0d", n, out_valid, fifo_level, m_q.size() > 0, m_q.size()); end
            n_checks++; if (out_addr !== 1'(m_oaddr) || out_time !== 16'(m_otime) || w_out_time !== 4'(m_otime % 16)) begin
                errors++; $display("FAIL rnd_head cyc=%0d got=a%0d t%0d w%0d want=a%0d t%0d", n, out_addr, out_time, w_out_time, m_oaddr, m_otime); end
            n_checks++; if (overflow !== m_ovf) begin
                errors++; $display("FAIL rnd_ovf cyc=%0d got=%0b want=%0b", n, overflow, m_ovf); end
`ifdef SPIKE_OUT_DROP_CNT_EN
            n_checks++; if (drop_count !== 8'(m_dcnt)) begin
                errors++; $display("FAIL rnd_dcnt cyc=%0d got=%0d want=%0d", n, drop_count, m_dcnt); end
`endif
        end
        time_en = 1'b1;
        overflow_clr = 1'b0;
        spk = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_collision();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spike_out_collector.md
Name: spike_out_collector

Overview:
- Collects single-cycle output spike pulses from the NUM_COLS neurons of the nn array, timestamps them and serialises them into one event stream.
- Sits directly downstream of the neuron columns.
- Delivers events through a valid/ready FIFO to the readout/transactor side.
- Arbitration is round-robin, so simultaneous spikes are never lost while buffer space exists.

Parameters:
- NUM_COLS, 2, number of neuron columns (spike inputs).
- TIME_WIDTH, 16, width of the timestamp counter.
- FIFO_DEPTH, 8, event FIFO entries (power of two, >=2).

Ports:
- clk  input  1  main clock (sys_if clk domain).
- reset_n  input  1  asynchronous, active-low reset.
- time_en  input  1  timestamp counter increments on clk edges where time_en=1.
- neuron_spike  input  NUM_COLS  one-cycle spike pulse per column.
- out_valid  output  1  FIFO head holds a valid event.
- out_ready  input  1  consumer accepts head event.
- out_addr  output  $clog2(NUM_COLS) (min 1)  column of head event.
- out_time  output  TIME_WIDTH  timestamp of head event.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: at least one spike lost.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset (async assert, sync deassert): time counter=0, pending=0, RR pointer=0, FIFO empty, out_valid=0, out_addr=0, out_time=0, fifo_level=0, overflow=0.
- Time counter:
  - Increments by 1 when time_en=1.
  - Wraps from 2^TIME_WIDTH-1 to 0; no flag on wrap.
- Capture: on each edge where neuron_spike[i]=1:
  - pending[i] is set.
  - stamp[i] is loaded with the current (pre-increment) counter value.
- Arbitration:
  - Each cycle, the round-robin arbiter grants the first pending column at or after the RR pointer, wrapping.
  - A grant occurs only if the FIFO can accept a push: level<FIFO_DEPTH, or a pop occurs in the same cycle.
  - On grant: push {i, stamp[i]}, clear pending[i], set RR pointer to i+1 mod NUM_COLS.
  - At most one push per cycle.
- Simultaneous grant and new spike on the same column: the new spike wins. pending[i] stays 1, stamp[i] takes the new time, and the old event is pushed.
- New spike on a column already pending and not granted this cycle:
  - Spike is dropped; the stored stamp is kept.
  - overflow is set on the next edge.
- FIFO full: pending bits hold; no grant; spikes accumulate in pending (one per column) until space frees.
- FIFO is first-word-fall-through:
  - out_valid = !empty.
  - out_addr/out_time show the head entry; they hold their last value while empty.
  - Pop on an edge with out_valid && out_ready. out_ready while empty is ignored.
  - Simultaneous push and pop: level unchanged, including at full.
- Latency:
  - Spike sampled at edge E0 is pushed at E1 if granted immediately.
  - out_valid rises after E1 when the FIFO was empty, i.e. 2 edges from pulse to visible event.
- Ordering: events leave in push order; timestamps from different columns may be non-monotonic only via round-robin fairness within the same pending window.
- overflow_clr:
  - Clears overflow on the next edge.
  - A drop in the same cycle takes priority and keeps overflow=1.

Optional Feature:
- Macro SPIKE_OUT_DROP_CNT_EN.
- When defined:
  - Adds output drop_count [7:0], reset 0.
  - Increments by the number of dropped spikes each cycle, saturating at 255.
  - Cleared by overflow_clr, except when a drop occurs in the same cycle, in which case drop_count loads that cycle's drop count.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Single spike: time_en=1, reset released at t=0, neuron_spike[1] pulsed when counter=5, out_ready=1 -> out_valid high 2 edges later with out_addr=1, out_time=5, for one cycle; fifo_level returns to 0.
- Simultaneous: both columns pulse at counter=10 with RR pointer=0 -> events (0,10) then (1,10) on consecutive cycles; next simultaneous pair at 20 -> (0,20),(1,20), since the pointer returned to 0 after granting column 1.
- Backpressure/full: out_ready=0, FIFO_DEPTH=8, 10 spikes alternating columns at 2-cycle spacing:
  - fifo_level saturates at 8 and both pending bits hold.
  - Later repeats on pending columns set overflow=1.
  - After raising out_ready, exactly 10 events drain in order with their original stamps.
- Same-column collision: column 0 pulses at t=3 and t=4 while out_ready=0 and the FIFO is full -> event t=3 kept, t=4 dropped, overflow=1; with SPIKE_OUT_DROP_CNT_EN, drop_count=1; overflow_clr -> both 0.
- Wrap: TIME_WIDTH=4, spike when counter=15, then another 2 cycles later -> out_time=15 then 1.
- Async reset mid-operation: reset_n low with 3 FIFO entries and 2 pending -> out_valid=0, fifo_level=0 and overflow=0 immediately without a clock edge; no stale events appear after release.
